// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_JAL       = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    typedef enum logic [2:0] {
        ULA_ADD   = 3'b000,
        ULA_SUB   = 3'b001,
        ULA_FUNCT = 3'b010,
        ULA_AND   = 3'b011,
        ULA_OR    = 3'b100,
        ULA_SLT   = 3'b101
    } ula_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Opcode dispatch out of DECODE; unknown opcodes trap.
    function automatic state_t dispatch(input logic [5:0] op);
        case (op)
            OP_RTYPE:                          return S_R_EXEC;
            OP_LW, OP_SW:                      return S_MEM_ADDR;
            OP_BEQ, OP_BNE:                    return S_BRANCH;
            OP_J:                              return S_JUMP;
            OP_JAL:                            return S_JAL;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return S_I_EXEC;
            default:                           return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_control_retire_counter.sv
// Retired-instruction counter; wraps naturally at 2^CNT_W.
module mips_mc_retire_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one per retiring instruction, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc)
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM driving datapath enables and mux selects.
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       ula_operation,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    state_t  state_q;
    state_t  state_n;
    ula_op_t ula_op;
    logic    retire_inc;

    assign state         = state_q;
    assign ula_operation = ula_op;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= S_FETCH;
        else
            state_q <= state_n;
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_n    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = REG_DST_RT;
        wb_sel     = WB_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        ula_op     = ULA_ADD;
        pc_source  = PC_SRC_ALU;
        illegal    = 1'b0;
        retire_inc = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    // Reset returns state to FETCH at once; mask the
                    // mem_ready-gated writes while it is still held.
                    ir_write = ~reset;
                    pc_write = ~reset;
                    state_n  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM_SH;
                state_n   = dispatch(opcode);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_n   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)
                    state_n = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REG_DST_RT;
                wb_sel     = WB_MDR;
                retire_inc = 1'b1;
                state_n    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire_inc = 1'b1;
                    state_n    = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_REG;
                ula_op    = ULA_FUNCT;
                state_n   = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REG_DST_RD;
                wb_sel     = WB_ALUOUT;
                retire_inc = 1'b1;
                state_n    = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_ANDI: ula_op = ULA_AND;
                    OP_ORI:  ula_op = ULA_OR;
                    OP_SLTI: ula_op = ULA_SLT;
                    default: ula_op = ULA_ADD;
                endcase
                state_n = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REG_DST_RT;
                wb_sel     = WB_ALUOUT;
                retire_inc = 1'b1;
                state_n    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_REG;
                ula_op     = ULA_SUB;
                pc_source  = PC_SRC_ALUOUT;
                pc_write   = (opcode == OP_BEQ) ? zero : ~zero;
                retire_inc = 1'b1;
                state_n    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PC_SRC_JUMP;
                retire_inc = 1'b1;
                state_n    = S_FETCH;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = PC_SRC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = REG_DST_RA;
                wb_sel     = WB_PC;
                retire_inc = 1'b1;
                state_n    = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    mips_mc_retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire (
        .clock(clock),
        .reset(reset),
        .inc  (retire_inc),
        .count(retired)
    );

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: directed sequences, a vector
// table and randomized instructions against an instruction-level model.
module tb_mips_mc_control;

    localparam int unsigned TB_CNT_W = 4;
    localparam int          MAXC     = 64;

    logic                clock = 1'b0;
    logic                reset;
    logic [5:0]          opcode;
    logic                zero;
    logic                mem_ready;
    logic                pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0]          reg_dst, wb_sel, alu_src_b, pc_source;
    logic                alu_src_a, illegal;
    logic [2:0]          ula_operation;
    logic [3:0]          state;
    logic [TB_CNT_W-1:0] retired;

    always #5 clock = ~clock;

    mips_mc_control #(.CNT_W(TB_CNT_W)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ula_operation(ula_operation), .pc_source(pc_source),
        .state(state), .retired(retired), .illegal(illegal)
    );

    typedef struct packed {
        logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
        logic [1:0] reg_dst, wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] ula;
        logic [1:0] pc_source;
        logic       illegal;
    } ctl_t;

    ctl_t cur;
    assign cur = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
                  reg_dst, wb_sel, alu_src_a, alu_src_b, ula_operation,
                  pc_source, illegal};

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_cyc;
    int   c_pcw, c_rw, c_mw, c_mr;
    bit   returned;
    int   ret_exp;
    logic [3:0] tr_st [MAXC];
    ctl_t       tr_ctl[MAXC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one instruction from FETCH, stalling FETCH fs cycles and the data
    // access ds cycles, and records the observed state/control trace.
    task automatic exec(input logic [5:0] op, input logic z, input int fs,
                        input int ds, input int max_cyc);
        int fsl, dsl;
        bit left;
        logic [3:0] st;
        fsl = fs; dsl = ds; left = 0; returned = 0;
        n_cyc = 0; c_pcw = 0; c_rw = 0; c_mw = 0; c_mr = 0;
        opcode = op;
        for (int k = 0; k < max_cyc; k++) begin
            st = state;
            if (st != 4'd0) left = 1;
            else if (left) begin
                returned = 1;
                break;
            end
            if (st == 4'd0) begin
                mem_ready = (fsl == 0);
                if (fsl > 0) fsl--;
            end else if (st == 4'd3 || st == 4'd5) begin
                mem_ready = (dsl == 0);
                if (dsl > 0) dsl--;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            zero = (st == 4'd8) ? z : 1'($urandom_range(0, 1));
            #1;
            tr_st[k]  = state;
            tr_ctl[k] = cur;
            c_pcw += int'(pc_write);
            c_rw  += int'(reg_write);
            c_mw  += int'(mem_write);
            c_mr  += int'(mem_read);
            n_cyc++;
            @(negedge clock);
        end
    endtask

    task automatic check_done(input string name);
        check({name, "_returned"}, 32'(returned), 32'd1);
        ret_exp++;
        check({name, "_retired"}, 32'(retired), 32'(ret_exp % 16));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_no_writes", 32'({pc_write, ir_write, reg_write, mem_write}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ret_exp = 0;
    endtask

    // Instruction-level reference: state path, strobe counts, cycle count.
    task automatic model_check(input logic [5:0] op, input logic z, input int fs, input int ds);
        int exp_st[$];
        int pcw, rw, mw, mr;
        for (int i = 0; i <= fs; i++) exp_st.push_back(0);
        exp_st.push_back(1);
        pcw = 1; rw = 0; mw = 0; mr = fs + 1;
        case (op)
            6'b100011: begin
                exp_st.push_back(2);
                for (int i = 0; i <= ds; i++) exp_st.push_back(3);
                exp_st.push_back(4);
                rw = 1; mr += ds + 1;
            end
            6'b101011: begin
                exp_st.push_back(2);
                for (int i = 0; i <= ds; i++) exp_st.push_back(5);
                mw = ds + 1;
            end
            6'b000000: begin exp_st.push_back(6); exp_st.push_back(7); rw = 1; end
            6'b000100: begin exp_st.push_back(8); pcw += (z ? 1 : 0); end
            6'b000101: begin exp_st.push_back(8); pcw += (z ? 0 : 1); end
            6'b000010: begin exp_st.push_back(9); pcw += 1; end
            6'b000011: begin exp_st.push_back(12); pcw += 1; rw = 1; end
            default:   begin exp_st.push_back(10); exp_st.push_back(11); rw = 1; end
        endcase
        check("rnd_cycles", 32'(n_cyc), 32'(exp_st.size()));
        for (int i = 0; i < n_cyc && i < exp_st.size(); i++)
            check("rnd_state", 32'(tr_st[i]), 32'(exp_st[i]));
        check("rnd_pcw", 32'(c_pcw), 32'(pcw));
        check("rnd_rw", 32'(c_rw), 32'(rw));
        check("rnd_mw", 32'(c_mw), 32'(mw));
        check("rnd_mr", 32'(c_mr), 32'(mr));
    endtask

    typedef struct {
        string      name;
        logic [5:0] op;
        logic       z;
        int         fs, ds;
        int         cyc, pcw, rw, mw, mr;
        bit         chk_ula;
        logic [2:0] ula;
    } vec_t;

    vec_t vt[$];
    logic [5:0] legal_ops[12];

    initial begin
        vt = '{
            '{"add",     6'b000000, 0, 0, 0, 4, 1, 1, 0, 1, 1, 3'b010},
            '{"lw",      6'b100011, 0, 0, 0, 5, 1, 1, 0, 2, 1, 3'b000},
            '{"lw_stl",  6'b100011, 0, 1, 3, 9, 1, 1, 0, 6, 1, 3'b000},
            '{"sw",      6'b101011, 0, 0, 0, 4, 1, 0, 1, 1, 1, 3'b000},
            '{"sw_stl",  6'b101011, 0, 0, 2, 6, 1, 0, 3, 1, 1, 3'b000},
            '{"beq_t",   6'b000100, 1, 0, 0, 3, 2, 0, 0, 1, 1, 3'b001},
            '{"beq_nt",  6'b000100, 0, 0, 0, 3, 1, 0, 0, 1, 1, 3'b001},
            '{"bne_t",   6'b000101, 0, 0, 0, 3, 2, 0, 0, 1, 1, 3'b001},
            '{"bne_nt",  6'b000101, 1, 0, 0, 3, 1, 0, 0, 1, 1, 3'b001},
            '{"j",       6'b000010, 0, 0, 0, 3, 2, 0, 0, 1, 0, 3'b000},
            '{"jal",     6'b000011, 0, 0, 0, 3, 2, 1, 0, 1, 0, 3'b000},
            '{"addi",    6'b001000, 0, 2, 0, 6, 1, 1, 0, 3, 1, 3'b000},
            '{"andi",    6'b001100, 0, 0, 0, 4, 1, 1, 0, 1, 1, 3'b011},
            '{"ori",     6'b001101, 0, 0, 0, 4, 1, 1, 0, 1, 1, 3'b100},
            '{"slti",    6'b001010, 0, 0, 0, 4, 1, 1, 0, 1, 1, 3'b101}
        };
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                      6'b000011, 6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000000};

        reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        ret_exp = 0;
        repeat (2) @(negedge clock);
        mem_ready = 1'b1;
        #1;
        check("rst_fetch_mem_read", 32'(mem_read), 32'd1);
        check("rst_fetch_src_b", 32'(alu_src_b), 32'd1);
        do_reset();

        // add: 0,1,6,7 then back to FETCH
        exec(6'b000000, 0, 0, 0, 20);
        check_done("add");
        check("add_cycles", 32'(n_cyc), 32'd4);
        check("add_path", {16'(tr_st[0]), 4'(tr_st[1]), 4'(tr_st[2]), 4'(tr_st[3]), 4'd0}, 32'h0000_1670);
        check("add_fetch_wr", 32'({tr_ctl[0].ir_write, tr_ctl[0].pc_write}), 32'd3);
        check("add_rexec", 32'({tr_ctl[2].alu_src_a, tr_ctl[2].alu_src_b, tr_ctl[2].ula}), 32'b1_00_010);
        check("add_rwb", 32'({tr_ctl[3].reg_write, tr_ctl[3].reg_dst, tr_ctl[3].wb_sel}), 32'b1_01_00);

        // lw with three data stalls: MEM_READ held four cycles
        exec(6'b100011, 0, 0, 3, 30);
        check_done("lw_stall");
        check("lw_stall_cycles", 32'(n_cyc), 32'd8);
        for (int i = 3; i <= 6; i++) begin
            check("lw_stall_state", 32'(tr_st[i]), 32'd3);
            check("lw_stall_rd", 32'({tr_ctl[i].mem_read, tr_ctl[i].i_or_d}), 32'd3);
        end
        check("lw_wb", 32'({tr_ctl[7].reg_write, tr_ctl[7].reg_dst, tr_ctl[7].wb_sel}), 32'b1_00_01);

        // beq taken / not taken, bne inverted
        exec(6'b000100, 1, 0, 0, 20);
        check_done("beq_t");
        check("beq_t_ctl", 32'({tr_ctl[2].pc_write, tr_ctl[2].pc_source, tr_ctl[2].ula}), 32'b1_01_001);
        exec(6'b000100, 0, 0, 0, 20);
        check_done("beq_nt");
        check("beq_nt_pcw", 32'(tr_ctl[2].pc_write), 32'd0);
        exec(6'b000101, 1, 0, 0, 20);
        check_done("bne_z1");
        check("bne_z1_pcw", 32'(tr_ctl[2].pc_write), 32'd0);

        // jal
        exec(6'b000011, 0, 0, 0, 20);
        check_done("jal");
        check("jal_state", 32'(tr_st[2]), 32'd12);
        check("jal_ctl", 32'({tr_ctl[2].pc_write, tr_ctl[2].reg_write, tr_ctl[2].reg_dst,
                              tr_ctl[2].wb_sel, tr_ctl[2].pc_source}), 32'b1_1_10_10_10);

        // vector table
        foreach (vt[i]) begin
            exec(vt[i].op, vt[i].z, vt[i].fs, vt[i].ds, 30);
            check_done(vt[i].name);
            check({vt[i].name, "_cycles"}, 32'(n_cyc), 32'(vt[i].cyc));
            check({vt[i].name, "_pcw"}, 32'(c_pcw), 32'(vt[i].pcw));
            check({vt[i].name, "_rw"}, 32'(c_rw), 32'(vt[i].rw));
            check({vt[i].name, "_mw"}, 32'(c_mw), 32'(vt[i].mw));
            check({vt[i].name, "_mr"}, 32'(c_mr), 32'(vt[i].mr));
            if (vt[i].chk_ula)
                check({vt[i].name, "_ula"}, 32'(tr_ctl[2 + vt[i].fs].ula), 32'(vt[i].ula));
        end

        // randomized instructions against the instruction-level model
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            logic       z;
            int         fs, ds;
            op = legal_ops[$urandom_range(0, 11)];
            z  = 1'($urandom_range(0, 1));
            fs = $urandom_range(0, 2);
            ds = $urandom_range(0, 2);
            exec(op, z, fs, ds, 30);
            check_done("rnd");
            model_check(op, z, fs, ds);
        end

        // counter wrap with a 4-bit counter
        do_reset();
        for (int n = 0; n < 16; n++) begin
            exec(6'b000010, 0, 0, 0, 20);
            check_done("wrap_j");
            if (n == 14) check("wrap_at_15", 32'(retired), 32'd15);
        end
        check("wrap_to_0", 32'(retired), 32'd0);

        // asynchronous reset during a FETCH stall
        exec(6'b000010, 0, 0, 0, 20);
        check_done("pre_rst_j");
        mem_ready = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_retired", 32'(retired), 32'd0);
        check("async_rst_no_wr", 32'({pc_write, ir_write}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ret_exp = 0;

        // asynchronous reset while stalled in MEM_READ
        opcode = 6'b100011;
        mem_ready = 1'b1;
        repeat (3) @(negedge clock);
        mem_ready = 1'b0;
        @(negedge clock);
        check("mid_lw_state", 32'(state), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_io", 32'({i_or_d, mem_write, reg_write}), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // illegal opcode traps, stays, freezes the counter
        exec(6'b000010, 0, 0, 0, 20);
        check_done("pre_trap_j");
        exec(6'b111111, 0, 0, 0, 10);
        check("trap_no_return", 32'(returned), 32'd0);
        check("trap_state", 32'(state), 32'd13);
        check("trap_illegal", 32'(illegal), 32'd1);
        check("trap_retired", 32'(retired), 32'(ret_exp % 16));
        check("trap_strobes", 32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 32'd0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
